// File: rtl/mux16_sched_pkg.sv
// Shared constants and state encoding for the 16-requester round-robin mux scheduler.
package mux16_sched_pkg;

    localparam int N_REQ            = 16;
    localparam int SEL_W            = 4;
    localparam int MAX_HOLD_DEFAULT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

endpackage

// File: rtl/mux16_rr_sched_rr_prio_enc.sv
// Combinational rotate-search: first set bit of vec_i at or after start_i, wrapping mod N_REQ.
module rr_prio_enc
    import mux16_sched_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    input  logic [SEL_W-1:0] start_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = start_i + SEL_W'(i);
            if (vec_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin owner scheduler driving the 16:1 mux select; sel_o[3:2] = slice, sel_o[1:0] = input.
// Optional forced preemption after MAX_HOLD busy cycles when MUX_SCHED_TIMEOUT_EN is defined.
module mux16_rr_sched
    import mux16_sched_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    output logic [SEL_W-1:0] sel_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic             valid_o,
`ifdef MUX_SCHED_TIMEOUT_EN
    output logic             timeout_o,
`endif
    output logic             dbg_state_o
);

    // Handshake: a requester holds req_i[n] high while it wants the mux; once gnt_o[n]
    // is seen it keeps ownership until it drops req_i[n], which releases at the next edge.

    sched_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] search_vec;
    logic [SEL_W-1:0] enc_idx;
    logic             enc_found;
    logic             owner_release;
    logic             preempt;
    logic             new_grant;

    // During handover the owner is masked so only other requesters are candidates.
    assign search_vec    = (state_q == IDLE) ? req_i : (req_i & ~gnt_q);
    assign owner_release = (state_q == BUSY) && !req_i[sel_q];

    rr_prio_enc u_enc (
        .vec_i   (search_vec),
        .start_i (ptr_q + SEL_W'(1)),
        .idx_o   (enc_idx),
        .found_o (enc_found)
    );

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    assign preempt = (state_q == BUSY) && req_i[sel_q] && (hold_q == HOLD_LAST) && enc_found;

    always_comb begin
        hold_d = hold_q;
        if (new_grant) begin
            hold_d = '0;
        end else if (state_q == BUSY && hold_q != HOLD_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        timeout_d = preempt && new_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 0);
    assign preempt         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                new_grant = enc_found;
            end
            BUSY: begin
                if (owner_release || preempt) begin
                    new_grant = enc_found;
                    if (!enc_found) begin
                        state_d = IDLE;
                        sel_d   = '0;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (new_grant) begin
            state_d = BUSY;
            sel_d   = enc_idx;
            gnt_d   = N_REQ'(1) << enc_idx;
            valid_d = 1'b1;
            ptr_d   = enc_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SEL_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel_o       = sel_q;
    assign gnt_o       = gnt_q;
    assign valid_o     = valid_q;
    assign dbg_state_o = (state_q == BUSY);

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed scenarios plus random traffic against a reference model.
module tb_mux16_rr_sched;

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
    localparam bit TO_EN       = 1'b1;
`else
    localparam int TB_MAX_HOLD = 64;
    localparam bit TO_EN       = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] req_i;
    logic [3:0]  sel_o;
    logic [15:0] gnt_o;
    logic        valid_o;
    logic        dbg_state_o;
`ifdef MUX_SCHED_TIMEOUT_EN
    logic        timeout_o;
`endif

    mux16_rr_sched #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .sel_o       (sel_o),
        .gnt_o       (gnt_o),
        .valid_o     (valid_o),
`ifdef MUX_SCHED_TIMEOUT_EN
        .timeout_o   (timeout_o),
`endif
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // reference model state
    logic        m_busy = 1'b0;
    logic [3:0]  m_sel  = 4'd0;
    logic [15:0] m_gnt  = 16'h0;
    logic [3:0]  m_ptr  = 4'd15;
    logic        m_to   = 1'b0;
    int          m_hold = 0;

    logic [21:0] exp_q[$];

    function automatic logic [4:0] first_from(input logic [15:0] v, input logic [3:0] p);
        for (int k = 1; k <= 16; k++) begin
            int j;
            j = (int'(p) + k) % 16;
            if (v[j]) return {1'b1, 4'(j)};
        end
        return 5'd0;
    endfunction

    task automatic model_grant(input logic [3:0] idx);
        m_busy = 1'b1;
        m_sel  = idx;
        m_gnt  = 16'h1 << idx;
        m_ptr  = idx;
        m_hold = 0;
    endtask

    // driver: apply one cycle of stimulus, predict, then compare after the edge
    task automatic step(input logic r, input logic [15:0] rq);
        logic [4:0]  hit;
        logic [15:0] pend;
        logic        pre;
        logic [21:0] e;
        @(negedge clk);
        rst   = r;
        req_i = rq;
        m_to  = 1'b0;
        if (r) begin
            m_busy = 1'b0; m_sel = 4'd0; m_gnt = 16'h0; m_ptr = 4'd15; m_hold = 0;
        end else if (!m_busy) begin
            hit = first_from(rq, m_ptr);
            if (hit[4]) model_grant(hit[3:0]);
        end else begin
            pend = rq & ~m_gnt;
            pre  = TO_EN && rq[m_sel] && (m_hold == TB_MAX_HOLD - 1) && (pend != 16'h0);
            if (!rq[m_sel] || pre) begin
                hit = first_from(pend, m_ptr);
                if (hit[4]) begin
                    model_grant(hit[3:0]);
                    m_to = pre;
                end else begin
                    m_busy = 1'b0; m_sel = 4'd0; m_gnt = 16'h0;
                end
            end else if (m_hold < TB_MAX_HOLD - 1) begin
                m_hold++;
            end
        end
        exp_q.push_back({m_to, m_busy, m_gnt, m_sel});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("sel", 32'(sel_o), 32'(e[3:0]));
        chk("gnt", 32'(gnt_o), 32'(e[19:4]));
        chk("valid", 32'(valid_o), 32'(e[20]));
        chk("state", 32'(dbg_state_o), 32'(e[20]));
`ifdef MUX_SCHED_TIMEOUT_EN
        chk("timeout", 32'(timeout_o), 32'(e[21]));
`endif
    endtask

    logic [3:0]  order [4];
    logic [15:0] cur;

    initial begin
        rst   = 1'b1;
        req_i = 16'h0;
        order[0] = 4'd0; order[1] = 4'd2; order[2] = 4'd15; order[3] = 4'd0;

        // reset with all requests asserted
        step(1'b1, 16'hFFFF);
        step(1'b1, 16'hFFFF);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        step(1'b0, 16'hFFFF);
        chk("first_grant_sel", 32'(sel_o), 32'd0);
        chk("first_grant_valid", 32'(valid_o), 32'd1);
        step(1'b0, 16'h0000);

        // rotation over 0, 2, 15, 0
        step(1'b1, 16'h0);
        step(1'b0, 16'h8005);
        for (int g = 0; g < 4; g++) begin
            chk("rot_order", 32'(sel_o), 32'(order[g]));
            step(1'b0, 16'h8005);
            step(1'b0, 16'h8005);
            step(1'b0, 16'h8005 & ~(16'h1 << order[g]));
        end

        // wrap: owner 15 releases, search restarts at 0
        step(1'b1, 16'h0);
        step(1'b0, 16'h8000);
        chk("wrap_owner15", 32'(sel_o), 32'd15);
        step(1'b0, 16'h0011);
        chk("wrap_to0", 32'(sel_o), 32'd0);
        step(1'b0, 16'h0010);
        chk("wrap_to4", 32'(sel_o), 32'd4);

        // back-to-back handover 3 -> 9 without an idle bubble
        step(1'b1, 16'h0);
        step(1'b0, 16'h0208);
        chk("b2b_owner3", 32'(sel_o), 32'd3);
        step(1'b0, 16'h0208);
        step(1'b0, 16'h0200);
        chk("b2b_sel9", 32'(sel_o), 32'd9);
        chk("b2b_valid", 32'(valid_o), 32'd1);

        // reset while busy with owner 7
        step(1'b1, 16'h0);
        step(1'b0, 16'h0080);
        step(1'b0, 16'h0080);
        step(1'b1, 16'h0080);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_gnt", 32'(gnt_o), 32'd0);
        step(1'b0, 16'h0080);
        chk("midrst_regrant", 32'(sel_o), 32'd7);

        // two persistent requesters: preempted only with the timeout feature
        step(1'b1, 16'h0);
        step(1'b0, 16'h0006);
        chk("hold_owner1", 32'(sel_o), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0006);
`ifdef MUX_SCHED_TIMEOUT_EN
        chk("to_owner2", 32'(sel_o), 32'd2);
        chk("to_pulse", 32'(timeout_o), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0004);
        chk("lone_kept", 32'(sel_o), 32'd2);
        chk("lone_no_pulse", 32'(timeout_o), 32'd0);
`else
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0006);
        chk("no_to_kept", 32'(sel_o), 32'd1);
`endif

        // random traffic against the model
        step(1'b1, 16'h0);
        cur = 16'h0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 16'($urandom) & 16'($urandom);
            if (m_busy && $urandom_range(0, 4) == 0) cur[m_sel] = 1'b0;
            step($urandom_range(0, 59) == 0, cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mux16_rr_sched.md
# mux16_rr_sched

Round-robin scheduler that shares the 16:1 gate-level mux between 16 requesters. It samples a 16-bit request vector and grants exactly one requester at a time. It drives the mux's 4-bit select so the data of the granted input reaches the mux output. It holds that select stable until the owner releases, then rotates fairly. It sits directly in front of the 16:1 mux select inputs; the two most-significant select bits choose the 4:1 slice and the two least-significant bits choose the input within the slice.

## Interface
- `MAX_HOLD`, default 64: maximum consecutive BUSY cycles for one owner while others wait (used only with the timeout feature).
- `clk`, in, 1: sole clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_i`, in, 16: request vector; bit n = input n wants the mux.
- `sel_o`, out, 4: mux select, binary index of the owner; [3:2] = slice, [1:0] = input within slice.
- `gnt_o`, out, 16: one-hot grant; all zero when idle.
- `valid_o`, out, 1: mux output carries granted data this cycle.
- `timeout_o`, out, 1: one-cycle pulse on forced preemption. Present only with `MUX_SCHED_TIMEOUT_EN`.

## Operation
- Two states: IDLE, BUSY.
- **Reset values:** state IDLE, `sel_o`=0, `gnt_o`=0, `valid_o`=0, `timeout_o`=0, last-owner pointer `ptr`=15, so the first search starts at input 0.
- **IDLE:**
  - If `req_i`≠0, pick the first set bit searching `ptr+1`, `ptr+2`, … with mod-16 wrap.
  - Load `sel_o` with that index, `gnt_o` with its one-hot, set `ptr` to it, and go to BUSY.
  - If `req_i`=0, remain in IDLE with all outputs 0.
- **BUSY:**
  - `valid_o`=1, and `sel_o` and `gnt_o` are frozen.
  - An owner releases by deasserting `req_i[sel_o]`.
  - On release with other requests pending, grant the next owner at the same edge, searching from `ptr+1`. There is no idle bubble.
  - On release with no other requests, go to IDLE and clear all outputs.
- Requests from non-owners never disturb the current grant.
- A released owner that re-requests immediately is searched last. This prevents starvation.
- `gnt_o` is always zero or one-hot, and `gnt_o[sel_o]`=`valid_o`.
- `rst` asserted mid-BUSY returns the block to reset values at that edge regardless of `req_i`.

## Timing
- All outputs are registered; there are no combinational paths from `req_i` to outputs.
- **Grant latency:** if `req_i` is sampled nonzero at edge k in IDLE, `gnt_o`/`sel_o`/`valid_o` are valid after edge k.
- **Handover:** if the owner drops its request before edge k, the new grant is visible after edge k.
- **Simultaneous requests:** the lowest index at or above `ptr+1` wins, with wrap-around.
- **Wrap boundary:** with `ptr`=15 the search starts at input 0; with `ptr`=0 it starts at input 1 and checks input 0 last.

## Configuration
- **`MUX_SCHED_TIMEOUT_EN` defined:**
  - A hold counter clears on each new grant and increments each BUSY cycle.
  - When the counter reaches `MAX_HOLD`−1 and another request is pending, the owner is preempted at the next edge.
  - The next owner is chosen by the normal rotation, and `timeout_o` pulses for one cycle.
  - A lone requester is never preempted; the counter saturates.
- **Undefined:** there is no counter and no `timeout_o` port, and owners hold indefinitely.

## Structure
- **Package `mux16_sched_pkg`:**
  - constants `N_REQ`=16 and `SEL_W`=4
  - state enum {IDLE, BUSY}
  - default `MAX_HOLD`
- **Sub-module `rr_prio_enc`:** combinational rotate-search. Inputs are the 16-bit vector and a 4-bit start index; outputs are the 4-bit index and a found flag.
- The top level instantiates one `rr_prio_enc`, masking the current owner during handover searches.

## Test plan
- **Reset:** `rst` high for 2 cycles with `req_i`=16'hFFFF → all outputs 0 and state IDLE. After release, first grant is input 0, with `sel_o`=0 one cycle later.
- **Rotation:** `req_i`=16'h8005, each owner dropping its request for one cycle after 3 BUSY cycles → grant order 0, 2, 15, 0.
- **Wrap:** owner 15 releases while `req_i`=16'h0011 → next `sel_o`=0, then 4.
- **Back-to-back handover:** inputs 3 and 9 requesting, owner 3 drops → `sel_o`=9 at the next edge with `valid_o` never low.
- **Mid-operation reset:** `rst` pulsed while BUSY with owner 7 → all outputs 0 next cycle. The following grant with `req_i`=16'h0080 is 7 (`ptr` was reset to 15).
- **Timeout (`MUX_SCHED_TIMEOUT_EN`, `MAX_HOLD`=4):** inputs 1 and 2 hold requests → owner 1 preempted after 4 BUSY cycles with a `timeout_o` pulse, owner 2 granted. A lone requester is never preempted.
